// File: rtl/bdir_line_ctrl.sv
// rtl/bdir_line_ctrl.sv - half-duplex single-wire line controller
//
// Purpose: serialises a request word onto a shared line (MSB first), releases
// the line for a turnaround gap, then optionally waits for a start bit and
// shifts in a response word MSB first.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   tx_valid/tx_ready  request handshake; tx_data and expect_rsp sampled with it
//   direction          1 = drive line from data_out, 0 = line released
//   data_out, data_in  serial line out / line value returned by the buffer
//   rx_valid, rx_data  one-cycle pulse with the received word (held afterwards)
//   err_timeout        one-cycle pulse when no start bit arrives in time
//   busy               high in every state except IDLE
module bdir_line_ctrl #(
  parameter int DATA_W      = 8,
  parameter int TURN_CYC    = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              expect_rsp,
  output logic              direction,
  output logic              data_out,
  input  logic              data_in,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              err_timeout,
  output logic              busy
);

  localparam int MAX_AB  = (DATA_W > TURN_CYC) ? DATA_W : TURN_CYC;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_TURN,
    S_RX_WAIT,
    S_RX_DATA
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  // One shift register serves both directions: TX shifts out at the MSB,
  // RX shifts in at the LSB, so a full RX phase overwrites any TX leftovers.
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              rsp, rsp_n;
  logic              rx_done;
  logic              tmo;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    rsp_n   = rsp;
    rx_done = 1'b0;
    tmo     = 1'b0;
    case (state)
      S_IDLE: begin
        // tx_ready is registered, so it stays low in the first cycle out of reset.
        if (tx_valid && tx_ready) begin
          state_n = S_TX;
          cnt_n   = '0;
          shreg_n = tx_data;
          rsp_n   = expect_rsp;
        end
      end
      S_TX: begin
        if (cnt == LAST_BIT) begin
          state_n = S_TURN;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          shreg_n = {shreg[DATA_W-2:0], 1'b0};
        end
      end
      S_TURN: begin
        // data_in is deliberately not looked at here: the far end may still be
        // settling the line.
        if (cnt == LAST_TURN) begin
          state_n = rsp ? S_RX_WAIT : S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RX_WAIT: begin
        if (data_in) begin
          state_n = S_RX_DATA;
          cnt_n   = '0;
        end else if (cnt == LAST_WAIT) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          tmo     = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RX_DATA: begin
        shreg_n = {shreg[DATA_W-2:0], data_in};
        if (cnt == LAST_BIT) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          rx_done = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      rsp         <= 1'b0;
      tx_ready    <= 1'b0;
      busy        <= 1'b0;
      direction   <= 1'b0;
      data_out    <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      rsp         <= rsp_n;
      tx_ready    <= (state_n == S_IDLE);
      busy        <= (state_n != S_IDLE);
      direction   <= (state_n == S_TX);
      data_out    <= (state_n == S_TX) && shreg_n[DATA_W-1];
      rx_valid    <= rx_done;
      err_timeout <= tmo;
      if (rx_done) begin
        rx_data <= shreg_n;
      end
    end
  end

endmodule
